// File: rtl/debug_dump_pkg.sv
// debug_dump_pkg: shared FSM/section encodings, header magic and word-count helper for the debug dump sequencer.
package debug_dump_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT_BUSY, ST_WAIT_EMPTY, ST_NEXT, ST_DONE} state_t;
  typedef enum logic [2:0] {SEC_HDR, SEC_PC, SEC_REG, SEC_MEM, SEC_CHK} section_t;
  localparam logic [15:0] DUMP_MAGIC = 16'hD0D0;
  function automatic logic [15:0] dump_word_count(input int nb_regs, input int nb_mem, input bit with_chk);
    return 16'(2 + nb_regs + nb_mem + (with_chk ? 1 : 0));
  endfunction
endpackage

// File: rtl/dump_word_mux.sv
// dump_word_mux: selects the word to transmit for the current dump section.
module dump_word_mux import debug_dump_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter logic [15:0] WORD_COUNT = 16'd66
) (
  input  section_t                section,
  input  logic [DATA_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0]   reg_data,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic [DATA_WIDTH-1:0]   chk,
  output logic [DATA_WIDTH-1:0]   word
);
  localparam logic [DATA_WIDTH-1:0] HDR = DATA_WIDTH'({DUMP_MAGIC, WORD_COUNT});
  always_comb
    word = section == SEC_HDR ? HDR :
           section == SEC_PC  ? pc :
           section == SEC_REG ? reg_data :
           section == SEC_MEM ? mem_data : chk;
endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: walks HDR, PC, registers and memory into the word transmitter; DUMP_CHECKSUM_EN appends an XOR checksum word.
module debug_dump_sequencer import debug_dump_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int NB_REGS      = 32,
  parameter int NB_MEM_WORDS = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_ADDR_W   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_dump_req,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_reg_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_tx_buffer_empty,
  output logic [REG_ADDR_W-1:0] o_reg_addr,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_pipeline_info,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_dump_done
);
`ifdef DUMP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam logic [15:0] WORD_COUNT = dump_word_count(NB_REGS, NB_MEM_WORDS, CHK_EN);
  localparam logic [REG_ADDR_W-1:0] REG_LAST = REG_ADDR_W'(NB_REGS - 1);
  localparam logic [MEM_ADDR_W-1:0] MEM_LAST = MEM_ADDR_W'(NB_MEM_WORDS - 1);
  state_t state, state_n;
  section_t section, section_n;
  logic [REG_ADDR_W-1:0] reg_addr_n;
  logic [MEM_ADDR_W-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] info_n, word, chk;
  logic tx_start_n, last;
  dump_word_mux #(.DATA_WIDTH(DATA_WIDTH), .WORD_COUNT(WORD_COUNT)) u_mux (
    .section(section), .pc(i_pc), .reg_data(i_reg_data), .mem_data(i_mem_data), .chk(chk), .word(word)
  );
`ifdef DUMP_CHECKSUM_EN
  // Every loaded word except CHK itself folds into the accumulator, so CHK covers all preceding words.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) chk <= '0;
    else chk <= state == ST_IDLE ? '0 : state == ST_LOAD ? chk ^ word : chk;
`else
  assign chk = '0;
`endif
  assign last = section == SEC_CHK || (section == SEC_MEM && o_mem_addr == MEM_LAST && !CHK_EN);
  assign o_busy = state != ST_IDLE;
  assign o_dump_done = state == ST_DONE;
  always_comb begin
    state_n = state;
    section_n = section;
    reg_addr_n = o_reg_addr;
    mem_addr_n = o_mem_addr;
    info_n = o_pipeline_info;
    tx_start_n = 1'b0;
    case (state)
      ST_IDLE:
        if (i_dump_req) begin
          state_n = ST_LOAD;
          section_n = SEC_HDR;
          reg_addr_n = '0;
          mem_addr_n = '0;
        end
      ST_LOAD: begin
        state_n = ST_WAIT_BUSY;
        info_n = word;
        tx_start_n = 1'b1;
      end
      ST_WAIT_BUSY: state_n = i_tx_buffer_empty ? ST_WAIT_BUSY : ST_WAIT_EMPTY;
      ST_WAIT_EMPTY: state_n = i_tx_buffer_empty ? ST_NEXT : ST_WAIT_EMPTY;
      ST_NEXT: begin
        state_n = last ? ST_DONE : ST_LOAD;
        case (section)
          SEC_HDR: section_n = SEC_PC;
          SEC_PC: section_n = SEC_REG;
          SEC_REG:
            if (o_reg_addr == REG_LAST) section_n = SEC_MEM;
            else reg_addr_n = o_reg_addr + 1'b1;
          SEC_MEM:
            if (o_mem_addr == MEM_LAST) section_n = SEC_CHK;
            else mem_addr_n = o_mem_addr + 1'b1;
          default: section_n = section;
        endcase
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= ST_IDLE;
      section <= SEC_HDR;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
      o_pipeline_info <= '0;
      o_tx_start <= 1'b0;
    end else begin
      state <= state_n;
      section <= section_n;
      o_reg_addr <= reg_addr_n;
      o_mem_addr <= mem_addr_n;
      o_pipeline_info <= info_n;
      o_tx_start <= tx_start_n;
    end
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: scoreboard bench with a 34-cycle transmitter model; honours DUMP_CHECKSUM_EN.
module tb_debug_dump_sequencer;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [31:0] HDR = 32'hD0D0000B;
  localparam int NW = 11;
`else
  localparam logic [31:0] HDR = 32'hD0D0000A;
  localparam int NW = 10;
`endif
  logic i_clk = 1'b0, i_reset = 1'b1, i_dump_req = 1'b0, i_tx_buffer_empty = 1'b1;
  logic [31:0] i_pc = 32'h40, i_reg_data, i_mem_data, o_pipeline_info;
  logic [1:0] o_reg_addr, o_mem_addr;
  logic o_tx_start, o_busy, o_dump_done;
  int n_cmp = 0, n_bad = 0, n_tx = 0, n_done = 0, tx_cnt = 0;
  int tx0, d0;
  logic [31:0] exp_q[$];
  always #5 i_clk = ~i_clk;
  assign i_reg_data = 32'h11 * {30'b0, o_reg_addr};
  assign i_mem_data = 32'h100 + {30'b0, o_mem_addr};
  debug_dump_sequencer #(.DATA_WIDTH(32), .NB_REGS(4), .NB_MEM_WORDS(4), .REG_ADDR_W(2), .MEM_ADDR_W(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_dump_req(i_dump_req), .i_pc(i_pc),
    .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_tx_buffer_empty(i_tx_buffer_empty),
    .o_reg_addr(o_reg_addr), .o_mem_addr(o_mem_addr), .o_pipeline_info(o_pipeline_info),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_dump_done(o_dump_done)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge i_clk) begin
    #1;
    if (i_reset) begin
      i_tx_buffer_empty = 1'b1;
      tx_cnt = 0;
    end else if (o_tx_start) begin
      i_tx_buffer_empty = 1'b0;
      tx_cnt = 34;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) i_tx_buffer_empty = 1'b1;
    end
  end
  always @(negedge i_clk)
    if (!i_reset) begin
      if (o_tx_start) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected no word", o_pipeline_info);
        end else check($sformatf("word%0d", n_tx), o_pipeline_info, exp_q.pop_front());
      end
      if (o_dump_done) n_done++;
    end
  task automatic push_dump();
    exp_q.push_back(HDR);
    exp_q.push_back(32'h40);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h11 * i);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + i);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(32'hD0D0004B);
`endif
  endtask
  task automatic pulse_req();
    @(negedge i_clk) i_dump_req = 1'b1;
    @(negedge i_clk) i_dump_req = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      if (o_dump_done) break;
    end
    if (k == 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no dump_done expected dump_done within 3000 cycles", name);
    end
  endtask
  task automatic wait_tx(input int target, input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      if (n_tx >= target) break;
    end
    if (k == 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d words expected %0d", name, n_tx, target);
    end
  endtask
  task automatic end_checks(input string name, input int words, input int dones);
    repeat (2) @(negedge i_clk);
    check({name, "_words"}, n_tx - tx0, words);
    check({name, "_done"}, n_done - d0, dones);
    check({name, "_queue"}, exp_q.size(), 0);
    check({name, "_busy"}, o_busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_dump_done, 0);
    check("rst_info", o_pipeline_info, 0);
    check("rst_reg_addr", o_reg_addr, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);
    check("idle_no_tx", n_tx, 0);
    check("idle_busy", o_busy, 0);
    push_dump();
    tx0 = n_tx; d0 = n_done;
    @(negedge i_clk) i_dump_req = 1'b1;
    @(negedge i_clk) i_dump_req = 1'b0;
    check("lat_busy", o_busy, 1);
    check("lat_no_start", o_tx_start, 0);
    @(negedge i_clk);
    check("lat_start", o_tx_start, 1);
    check("lat_hdr", o_pipeline_info, HDR);
    wait_done("dump1");
    end_checks("dump1", NW, 1);
    push_dump();
    tx0 = n_tx; d0 = n_done;
    pulse_req();
    wait_tx(tx0 + 4, "repulse_wait");
    pulse_req();
    wait_done("repulse");
    repeat (100) @(negedge i_clk);
    end_checks("repulse", NW, 1);
    push_dump();
    tx0 = n_tx;
    pulse_req();
    wait_tx(tx0 + 5, "rst_mid_wait");
    repeat (10) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_tx", o_tx_start, 0);
    check("rst_mid_reg_addr", o_reg_addr, 0);
    exp_q.delete();
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    push_dump();
    tx0 = n_tx; d0 = n_done;
    pulse_req();
    wait_done("restart");
    end_checks("restart", NW, 1);
    push_dump();
    push_dump();
    tx0 = n_tx; d0 = n_done;
    @(negedge i_clk) i_dump_req = 1'b1;
    wait_done("held1");
    @(negedge i_clk);
    check("held_idle", o_busy, 0);
    @(negedge i_clk);
    check("held_load", o_busy, 1);
    i_dump_req = 1'b0;
    @(negedge i_clk);
    check("held_start", o_tx_start, 1);
    wait_done("held2");
    end_checks("held", 2 * NW, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
